serial_subtractor32: RTL and testbench

Bit-serial two's-complement subtractor that computes d = a - b one bit per clock, LSB first, with borrow-out. It is the inverse operation to the team's 32-bit ripple-carry adder: it recovers an addend from a sum. It is a small-area alternative for datapaths that can tolerate WIDTH-cycle latency. A start/busy/done handshake connects it to a controlling FSM.

---
 rtl/serial_subtractor32.sv | 125 ++++++++++++
 tb/tb_serial_subtractor32.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor32.sv
// Bit-serial two's-complement subtractor, LSB first.
// start/busy/done handshake; d and bout update only on entry to DONE.
module serial_subtractor32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CNT_W-1:0] cnt;

  logic             x;
  logic             y;
  logic             dbit;
  logic             brw_nx;
  logic             last;
  logic             load;
  logic [WIDTH-1:0] res_nx;

  assign x      = sh_a[0];
  assign y      = sh_b[0];
  assign dbit   = x ^ y ^ brw;
  assign brw_nx = (~x & y) | (~(x ^ y) & brw);
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign load   = (state == S_IDLE) && start;
  assign res_nx = {dbit, res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a <= '0;
      sh_b <= '0;
      res  <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      sh_a <= a;
      sh_b <= b;
      res  <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (state == S_SHIFT) begin
      sh_a <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b <= {1'b0, sh_b[WIDTH-1:1]};
      res  <= res_nx;
      brw  <= brw_nx;
      cnt  <= cnt + 1'b1;
    end
  end

  // Results are captured on the final shift so they never show partials.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d    <= '0;
      bout <= 1'b0;
    end else if ((state == S_SHIFT) && last) begin
      d    <= res_nx;
      bout <= brw_nx;
    end
  end

endmodule

// File: tb/tb_serial_subtractor32.sv
// Directed bench for serial_subtractor32 with a result scoreboard.
// Expected {bout, d} is computed from a - b when each operation is driven.
module tb_serial_subtractor32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W:0] sb[$];

  always #5 clk = ~clk;

  serial_subtractor32 #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y);
    logic [W-1:0] diff;
    diff = x - y;
    return {(x < y), diff};
  endfunction

  task automatic check_pop(input string tag);
    logic [W:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_d"}, 64'(d), 64'(e[W-1:0]));
      chk({tag, "_bout"}, 64'(bout), 64'(e[W]));
    end
  endtask

  // Called at a negedge. Drives one op, waits for done, checks it.
  task automatic run_op(input string tag,
                        input logic [W-1:0] xa,
                        input logic [W-1:0] xb,
                        input int poke,
                        input logic [W-1:0] pa,
                        input logic [W-1:0] pb);
    int cyc;
    int nb;
    bit seen;
    a = xa;
    b = xb;
    start = 1'b1;
    sb.push_back(model(xa, xb));
    cyc = 0;
    nb = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 || cyc == poke + 1) start = 1'b0;
      if (poke != 0 && cyc == poke) begin
        a = pa;
        b = pb;
        start = 1'b1;
      end
      if (busy) nb++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_lat"}, 64'(cyc), 64'd33);
      chk({tag, "_busy_cnt"}, 64'(nb), 64'd32);
      check_pop(tag);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
      chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int first;
    int second;
    int cyc;
    int nd;
    logic [W-1:0] hd;
    logic hb;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_d", 64'(d), 64'd0);
    chk("rst_bout", 64'(bout), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("basic", 32'h0080_0800, 32'h0002_0000, 0, '0, '0);
    run_op("brw0", 32'h0000_0000, 32'h0000_0001, 0, '0, '0);
    run_op("brw1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0, '0);

    // Start pulse at cycle 10 with new operands must be ignored.
    run_op("mixed", 32'h0100_0000, 32'h0020_3800,
           10, 32'hDEAD_BEEF, 32'h1234_5678);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mixed_no_2nd_done", 64'(nd), 64'd0);
    chk("mixed_hold_d", 64'(d), 64'h00DF_C800);

    // Back-to-back with start held high.
    a = 32'h5;
    b = 32'h3;
    start = 1'b1;
    sb.push_back(model(32'h5, 32'h3));
    sb.push_back(model(32'h3, 32'h5));
    cyc = 0;
    first = 0;
    second = 0;
    while (second == 0 && cyc < 150) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        a = 32'h3;
        b = 32'h5;
      end
      if (done) begin
        if (first == 0) begin
          first = cyc;
          check_pop("b2b_1");
        end else begin
          second = cyc;
          start = 1'b0;
          check_pop("b2b_2");
        end
      end
    end
    chk("b2b_first_lat", 64'(first), 64'd33);
    chk("b2b_gap", 64'(second - first), 64'd34);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    a = 32'h1234_5678;
    b = 32'h0000_0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_d", 64'(d), 64'd0);
    chk("mid_rst_bout", 64'(bout), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("mid_no_done", 64'(nd), 64'd0);
    run_op("fresh", 32'h1234_5678, 32'h0000_0001, 0, '0, '0);

    // Outputs hold while idle.
    run_op("hold", 32'h0080_0800, 32'h0002_0000, 0, '0, '0);
    hd = 32'h007E_0800;
    hb = 1'b0;
    repeat (50) begin
      @(negedge clk);
      chk("hold_d", 64'(d), 64'(hd));
      chk("hold_bout", 64'(bout), 64'(hb));
      chk("hold_done", 64'(done), 64'd0);
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
